// File: rtl/counter_pkg.sv
// Shared types, 7-segment patterns and elaboration helpers for the BCD timer.
package counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Active-low segments, bit order a..g with a in the MSB.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int MAX_DIGITS = 6;

    function automatic int prescaler_width(input int clk_hz, input int tick_hz);
        return $clog2(clk_hz / tick_hz);
    endfunction

    // Elaboration-time only: turns a parameter value into packed BCD.
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit BCD to active-low 7-segment decoder with a blanking input.
module seg7_decoder
    import counter_pkg::*;
(
    input  bcd_digit_t  bcd_i,
    input  logic        blank_i,
    output logic [6:0]  seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_timer_counter.sv
// Prescaled modulo-N BCD up/down counter with per-digit 7-segment outputs.
// Define BCD_TIMER_LZ_BLANK_EN to blank leading zero digits on hex_o.
module bcd_timer_counter
    import counter_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 2,
    parameter int MODULO  = 60
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                up_i,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [4*DIGITS-1:0] load_val_i,
    output logic [4*DIGITS-1:0] count_bcd_o,
    output logic [7*DIGITS-1:0] hex_o,
    output logic                tick_o,
    output logic                wrap_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = prescaler_width(CLK_HZ, TICK_HZ);
    localparam int NW  = 4 * DIGITS;
    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);
    localparam logic [4*MAX_DIGITS-1:0] MAX_BCD_FULL = int_to_bcd(MODULO - 1);
    localparam logic [NW-1:0] MAX_BCD = MAX_BCD_FULL[NW-1:0];

    logic [PW-1:0] presc_q, presc_d;
    logic [NW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    logic [NW-1:0] inc_bcd, dec_bcd;
    logic          carry, borrow;
    logic          at_max, at_zero, load_ok;

    always_comb begin
        inc_bcd = count_q;
        carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    inc_bcd[4*k +: 4] = 4'd0;
                end else begin
                    inc_bcd[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        dec_bcd = count_q;
        borrow  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    dec_bcd[4*k +: 4] = 4'd9;
                end else begin
                    dec_bcd[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign at_max  = (count_q == MAX_BCD);
    assign at_zero = (count_q == '0);

    // Once every nibble is a valid digit, packed-BCD order matches numeric order.
    always_comb begin
        load_ok = (load_val_i <= MAX_BCD);
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val_i[4*k +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear_i) begin
            count_d = '0;
            presc_d = '0;
        end else if (load_i) begin
            count_d = load_ok ? load_val_i : '0;
            presc_d = '0;
        end else if (enable_i) begin
            if (presc_q == PRESC_TC) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (up_i) begin
                    count_d = at_max ? '0 : inc_bcd;
                    wrap_d  = at_max;
                end else begin
                    count_d = at_zero ? MAX_BCD : dec_bcd;
                    wrap_d  = at_zero;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    logic [DIGITS-1:0] blank;

`ifdef BCD_TIMER_LZ_BLANK_EN
    // Digit k blanks only when it and every digit above it are zero.
    logic upper_zero;
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (count_q[4*k +: 4] == 4'd0);
            blank[k]   = upper_zero;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_decoder u_seg (
            .bcd_i   (count_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (hex_o[7*g +: 7])
        );
    end

    assign count_bcd_o = count_q;
    assign tick_o      = tick_q;
    assign wrap_o      = wrap_q;

endmodule
